// File: rtl/shift_chain_pkg.sv
// Shared types for the multi-lane serial shift engine.
// Controller state encoding and shift direction constants.
package shift_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_lane.sv
// One WIDTH-bit lane register with parallel load and bidirectional shift.
// Serial out tap follows the registered direction, never a live input.
module shift_lane
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             out_dir,
  input  logic             in,
  output logic [WIDTH-1:0] q,
  output logic             out
);

  // lane register: load wins over shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_RIGHT) begin
        q <= {in, q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], in};
      end
    end
  end

  // serial tap on the end the data leaves from
  always_comb begin
    out = (out_dir == DIR_RIGHT) ? q[0] : q[WIDTH-1];
  end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Shared controller for LANES lockstep shift lanes.
// Handles load, counted bursts with busy/done, and free-run shifting.
module shift_chain_ctrl
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic                   clk,
  input  logic                   ap_rst_n,
  input  logic [LANES-1:0]       in,
  output logic [LANES-1:0]       out,
  input  logic                   shiftr,
  input  logic                   load,
  input  logic [LANES*WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic [CNT_W-1:0]       count,
  input  logic                   free_run,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*WIDTH-1:0] par_out
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;
  logic             idle;
  logic             ld_en;
  logic             sh_en;
  logic             sh_dir;

  // state register
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next state; load in IDLE shadows a same-cycle start
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (!load && start) begin
          nxt = (count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt <= CNT_W'(1)) begin
          nxt = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // lane controls and handshake outputs
  always_comb begin
    idle   = (state == IDLE);
    busy   = !idle;
    done   = (state == DONE);
    ld_en  = idle && load;
    sh_en  = 1'b0;
    sh_dir = dir_q;
    unique case (1'b1)
      idle: begin
        sh_en  = !load && !start && free_run;
        sh_dir = shiftr;
      end
      (state == SHIFT): sh_en = 1'b1;
      default: ;
    endcase
  end

  // burst counter and latched direction
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt   <= '0;
      dir_q <= DIR_LEFT;
    end else begin
      unique case (state)
        IDLE: begin
          if (!load && start) begin
            cnt   <= count;
            dir_q <= shiftr;
          end else if (!load && free_run) begin
            dir_q <= shiftr;
          end
        end
        SHIFT:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // one register per lane, all driven by the same controls
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    shift_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (ap_rst_n),
      .load     (ld_en),
      .load_data(load_data[l*WIDTH +: WIDTH]),
      .shift_en (sh_en),
      .dir      (sh_dir),
      .out_dir  (dir_q),
      .in       (in[l]),
      .q        (par_out[l*WIDTH +: WIDTH]),
      .out      (out[l])
    );
  end

endmodule
